// File: rtl/clz_pkg.sv
// Shared types and elaboration-time helpers for the pipelined leading-count tree.
package clz_pkg;

  typedef enum logic {
    CLZ_MODE_ZEROS = 1'b0,
    CLZ_MODE_ONES  = 1'b1
  } clz_mode_e;

  function automatic int clz_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

  // Earlier stages absorb the remainder when levels do not divide evenly.
  function automatic int levels_in_stage(input int stage, input int total_levels, input int stages);
    int base;
    int extra;
    base  = total_levels / stages;
    extra = total_levels % stages;
    return base + ((stage < extra) ? 1 : 0);
  endfunction

  function automatic int level_stage(input int level, input int total_levels, input int stages);
    int acc;
    int found;
    acc   = 0;
    found = -1;
    for (int s = 0; s < stages; s++) begin
      acc = acc + levels_in_stage(s, total_levels, stages);
      if (found < 0 && level < acc) found = s;
    end
    return found;
  endfunction

  function automatic bit level_ends_stage(input int level, input int total_levels, input int stages);
    if (level == total_levels - 1) return 1'b1;
    return level_stage(level + 1, total_levels, stages) != level_stage(level, total_levels, stages);
  endfunction

endpackage

// File: rtl/clz_merge.sv
// Combines the {all_zero, count} results of two adjacent HALF_W-bit groups.
module clz_merge import clz_pkg::*; #(
  parameter int HALF_W = 2
) (
  input  logic                      l_all,
  input  logic [$clog2(HALF_W):0]   l_cnt,
  input  logic                      r_all,
  input  logic [$clog2(HALF_W):0]   r_cnt,
  output logic                      m_all,
  output logic [$clog2(HALF_W)+1:0] m_cnt
);

  localparam int CWH = clz_cnt_w(HALF_W);
  localparam logic [CWH:0] HALF = HALF_W[CWH:0];

  always_comb begin
    m_all = l_all & r_all;
    m_cnt = l_all ? (HALF + {1'b0, r_cnt}) : {1'b0, l_cnt};
  end

endmodule

// File: rtl/clz_pipe.sv
// Pipelined leading-zero / leading-one counter with valid/ready stages and bubble collapsing.
module clz_pipe import clz_pkg::*; #(
  parameter  int WIDTH       = 32,
  parameter  int PIPE_STAGES = 2,
  parameter  int TAG_W       = 4,
  localparam int CW          = clz_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_all,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LEVELS = $clog2(WIDTH);

  clz_mode_e            mode;
  logic [WIDTH-1:0]     op;
  logic [PIPE_STAGES-1:0] ready;
  logic [PIPE_STAGES-1:0] load;
  logic [PIPE_STAGES-1:0] valid_d, valid_q;
  logic [TAG_W-1:0]     tag_d [PIPE_STAGES];
  logic [TAG_W-1:0]     tag_q [PIPE_STAGES];

  // Leading ones are counted as leading zeros of the inverted operand.
  assign mode = clz_mode_e'(in_mode);
  assign op   = (mode == CLZ_MODE_ONES) ? ~in_data : in_data;

  always_comb begin : ready_chain
    logic chain;
    chain = out_ready;
    ready = '0;
    for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
      chain    = ~valid_q[s] | chain;
      ready[s] = chain;
    end
  end

  always_comb begin
    load       = '0;
    valid_d    = valid_q;
    load[0]    = ready[0] & in_valid;
    valid_d[0] = ready[0] ? in_valid : valid_q[0];
    tag_d[0]   = load[0] ? in_tag : tag_q[0];
    for (int s = 1; s < PIPE_STAGES; s++) begin
      load[s]    = ready[s] & valid_q[s-1];
      valid_d[s] = ready[s] ? valid_q[s-1] : valid_q[s];
      tag_d[s]   = load[s] ? tag_q[s-1] : tag_q[s];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) tag_q[s] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int s = 0; s < PIPE_STAGES; s++) tag_q[s] <= tag_d[s];
    end
  end

  // Each level packs its groups as {all, count}, group 0 at the least significant end.
  for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
    localparam int NG   = WIDTH >> (j + 1);
    localparam int FW   = j + 3;
    localparam int STG  = level_stage(j, LEVELS, PIPE_STAGES);
    localparam bit ENDS = level_ends_stage(j, LEVELS, PIPE_STAGES);

    logic [NG*FW-1:0] res_o;

    if (j == 0) begin : g_leaf
      for (genvar g = 0; g < NG; g++) begin : g_grp
        logic [1:0] b;
        assign b = op[2*g +: 2];
        assign res_o[g*FW +: FW] = {~|b, b[1] ? 2'd0 : (b[0] ? 2'd1 : 2'd2)};
      end
    end else begin : g_tree
      localparam int PFW = j + 2;
      logic [2*NG*PFW-1:0] src;

      if (level_ends_stage(j - 1, LEVELS, PIPE_STAGES)) begin : g_from_reg
        assign src = g_lvl[j-1].g_reg.res_q;
      end else begin : g_from_comb
        assign src = g_lvl[j-1].res_o;
      end

      for (genvar g = 0; g < NG; g++) begin : g_grp
        clz_merge #(.HALF_W(1 << j)) u_merge (
          .l_all (src[(2*g+1)*PFW + PFW - 1]),
          .l_cnt (src[(2*g+1)*PFW +: PFW-1]),
          .r_all (src[(2*g)*PFW + PFW - 1]),
          .r_cnt (src[(2*g)*PFW +: PFW-1]),
          .m_all (res_o[g*FW + FW - 1]),
          .m_cnt (res_o[g*FW +: FW-1])
        );
      end
    end

    if (ENDS) begin : g_reg
      logic [NG*FW-1:0] res_d, res_q;

      always_comb begin
        res_d = res_q;
        if (load[STG]) res_d = res_o;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) res_q <= '0;
        else        res_q <= res_d;
      end
    end
  end

  assign in_ready  = ready[0];
  assign out_valid = valid_q[PIPE_STAGES-1];
  assign out_tag   = tag_q[PIPE_STAGES-1];
  assign out_count = g_lvl[LEVELS-1].g_reg.res_q[CW-1:0];
  assign out_all   = g_lvl[LEVELS-1].g_reg.res_q[CW];

endmodule

// File: tb/tb_clz_pipe.sv
// Self-checking bench for clz_pipe: directed scenarios plus a randomized stream scored against a bit-scan model.
module tb_clz_pipe;

  localparam int WIDTH       = 32;
  localparam int PIPE_STAGES = 2;
  localparam int TAG_W       = 4;
  localparam int CW          = 6;
  localparam int RW          = 1 + CW + TAG_W;

  typedef logic [RW-1:0] rec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_mode = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [CW-1:0]    out_count;
  logic             out_all;
  logic [TAG_W-1:0] out_tag;

  rec_t exp_q[$];
  rec_t got_q[$];
  int   checks = 0;
  int   errors = 0;

  clz_pipe #(.WIDTH(WIDTH), .PIPE_STAGES(PIPE_STAGES), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_all   (out_all),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  // Reference: scan from the MSB for the first bit that differs from the counted value.
  function automatic rec_t ref_result(input logic [WIDTH-1:0] d, input logic m, input logic [TAG_W-1:0] t);
    logic [WIDTH-1:0] x;
    int n;
    x = m ? ~d : d;
    n = 0;
    while (n < WIDTH && x[WIDTH-1-n] == 1'b0) n++;
    return {(n == WIDTH), n[CW-1:0], t};
  endfunction

  // Transfers are decided on the next rising edge; inputs only change just after rising edges.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready)   exp_q.push_back(ref_result(in_data, in_mode, in_tag));
      if (out_valid && out_ready) got_q.push_back({out_all, out_count, out_tag});
    end
  end

  task automatic send_beat(input logic [WIDTH-1:0] d, input logic m, input logic [TAG_W-1:0] t, output bit ok);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_tag   = t;
    ok       = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(output bit timed_out);
    out_ready = 1'b1;
    timed_out = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (got_q.size() >= exp_q.size() && !out_valid) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b want 0", out_valid); end
    checks++;
    if (out_count !== '0 || out_all !== 1'b0 || out_tag !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got count=%0d all=%0b tag=%0d want 0/0/0", out_count, out_all, out_tag);
    end
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release got in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_latency();
    bit ok, to;
    exp_q.delete();
    got_q.delete();
    out_ready = 1'b1;
    send_beat(32'h0001_0000, 1'b0, 4'd3, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL latency_accept got no accept want accept"); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_early got out_valid=%0b want 0", out_valid); end
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_all, out_count, out_tag} !== {1'b1, 1'b0, 6'd15, 4'd3}) begin
      errors++;
      $display("[TB] FAIL latency_result got v=%0b all=%0b count=%0d tag=%0d want 1/0/15/3",
               out_valid, out_all, out_count, out_tag);
    end
    drain(to);
    checks++;
    if (to || got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      errors++;
      $display("[TB] FAIL latency_model got %0d results want 1 matching model (timeout=%0b)", got_q.size(), to);
    end
  endtask

  task automatic test_back_to_back();
    bit ok_a, ok_b, to;
    exp_q.delete();
    got_q.delete();
    out_ready = 1'b1;
    send_beat(32'h0000_0000, 1'b0, 4'd1, ok_a);
    send_beat(32'hFFFF_FFFF, 1'b1, 4'd2, ok_b);
    checks++;
    if ({out_valid, out_all, out_count, out_tag} !== {1'b1, 1'b1, 6'd32, 4'd1}) begin
      errors++;
      $display("[TB] FAIL b2b_first got v=%0b all=%0b count=%0d tag=%0d want 1/1/32/1",
               out_valid, out_all, out_count, out_tag);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_all, out_count, out_tag} !== {1'b1, 1'b1, 6'd32, 4'd2}) begin
      errors++;
      $display("[TB] FAIL b2b_second got v=%0b all=%0b count=%0d tag=%0d want 1/1/32/2",
               out_valid, out_all, out_count, out_tag);
    end
    drain(to);
    checks++;
    if (!ok_a || !ok_b || to || got_q.size() != 2) begin
      errors++;
      $display("[TB] FAIL b2b_count got %0d results want 2 (accepts %0b%0b timeout %0b)", got_q.size(), ok_a, ok_b, to);
    end
  endtask

  task automatic test_boundary();
    bit ok_a, ok_b, to;
    exp_q.delete();
    got_q.delete();
    out_ready = 1'b1;
    send_beat(32'hFFF0_0000, 1'b1, 4'd5, ok_a);
    send_beat(32'h8000_0000, 1'b0, 4'd6, ok_b);
    drain(to);
    checks++;
    if (!ok_a || !ok_b || to || got_q.size() != 2) begin
      errors++;
      $display("[TB] FAIL boundary_count got %0d results want 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== {1'b0, 6'd12, 4'd5}) begin
        errors++;
        $display("[TB] FAIL boundary_ones12 got %h want %h", got_q[0], {1'b0, 6'd12, 4'd5});
      end
      checks++;
      if (got_q[1] !== {1'b0, 6'd0, 4'd6} || got_q[1] !== exp_q[1]) begin
        errors++;
        $display("[TB] FAIL boundary_msb got %h want %h", got_q[1], {1'b0, 6'd0, 4'd6});
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] bp_data [6];
    rec_t snap;
    int   k;
    bit   acc, to;
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < 6; i++) bp_data[i] = $urandom >> $urandom_range(0, 31);
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      in_data  = bp_data[k];
      in_mode  = 1'b0;
      in_tag   = TAG_W'(k);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
    end
    checks++;
    if (k != 2) begin errors++; $display("[TB] FAIL bp_accepted got %0d want 2", k); end
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_full got in_ready=%0b out_valid=%0b want 0/1", in_ready, out_valid);
    end
    snap = {out_all, out_count, out_tag};
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_all, out_count, out_tag} !== snap) begin
      errors++;
      $display("[TB] FAIL bp_hold got %h want %h", {out_all, out_count, out_tag}, snap);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_rise got %0b want 1", in_ready); end
    for (int c = 0; c < 30 && k < 6; c++) begin
      in_valid = 1'b1;
      in_data  = bp_data[k];
      in_tag   = TAG_W'(k);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
    end
    in_valid = 1'b0;
    drain(to);
    checks++;
    if (to || got_q.size() != 6 || exp_q.size() != 6) begin
      errors++;
      $display("[TB] FAIL bp_total got %0d results want 6 (timeout %0b)", got_q.size(), to);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i] || got_q[i][TAG_W-1:0] !== TAG_W'(i)) begin
          errors++;
          $display("[TB] FAIL bp_order[%0d] got %h want %h tag %0d", i, got_q[i], exp_q[i], i);
        end
      end
    end
  endtask

  task automatic test_bubble();
    bit ok_a, ok_b, to;
    exp_q.delete();
    got_q.delete();
    out_ready = 1'b0;
    send_beat(32'h0000_00F0, 1'b0, 4'd9, ok_a);
    @(posedge clk);
    #1;
    send_beat(32'h3FFF_FFFF, 1'b1, 4'd10, ok_b);
    @(posedge clk);
    #1;
    checks++;
    if (!ok_a || !ok_b || in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 4'd9) begin
      errors++;
      $display("[TB] FAIL bubble_held got acc=%0b%0b in_ready=%0b out_valid=%0b tag=%0d want 11/0/1/9",
               ok_a, ok_b, in_ready, out_valid, out_tag);
    end
    drain(to);
    checks++;
    if (to || got_q.size() != 2 || exp_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
      errors++;
      $display("[TB] FAIL bubble_drain got %0d results want 2 matching model", got_q.size());
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] d;
    bit acc, to;
    exp_q.delete();
    got_q.delete();
    acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || acc) begin
        d = $urandom >> $urandom_range(0, 32);
        in_mode = 1'($urandom_range(0, 1));
        if (in_mode && $urandom_range(0, 3) != 0) d = ~d;
        in_data  = d;
        in_tag   = TAG_W'($urandom);
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain(to);
    checks++;
    if (to || got_q.size() != exp_q.size() || got_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL random_count got %0d results want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("[TB] FAIL random[%0d] got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    bit ok_a, ok_b, saw_valid;
    exp_q.delete();
    got_q.delete();
    out_ready = 1'b0;
    send_beat(32'h0000_1234, 1'b0, 4'd7, ok_a);
    send_beat(32'h00FF_0000, 1'b0, 4'd8, ok_b);
    checks++;
    if (!ok_a || !ok_b || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_pre got acc=%0b%0b out_valid=%0b want 11/1", ok_a, ok_b, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_all, out_count, out_tag} !== '0) begin
      errors++;
      $display("[TB] FAIL rst_async got v=%0b all=%0b count=%0d tag=%0d want all 0",
               out_valid, out_all, out_count, out_tag);
    end
    exp_q.delete();
    got_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready got %0b want 1", in_ready); end
    saw_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) saw_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (saw_valid || got_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL rst_flush got valid_seen=%0b results=%0d want 0/0", saw_valid, got_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_boundary();
    test_backpressure();
    test_bubble();
    test_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
